// File: rtl/riscv_bht_if.sv
// riscv_bht_if: fetch-lookup and execute-resolution signals of the branch history table
interface riscv_bht_if;
  logic [63:0] i_riscv_bht_fetch_pc;
  logic        o_riscv_bht_pred_taken;
  logic [63:0] o_riscv_bht_pred_target;
  logic        i_riscv_bht_ex_valid;
  logic        i_riscv_bht_ex_stall;
  logic [63:0] i_riscv_bht_ex_pc;
  logic        i_riscv_bht_ex_taken;
  logic [63:0] i_riscv_bht_ex_target;
  logic        i_riscv_bht_ex_pred_taken;
  logic [63:0] i_riscv_bht_ex_pred_target;
  logic        o_riscv_bht_mispredict;
  logic [63:0] o_riscv_bht_redirect_pc;
  modport master (
    output i_riscv_bht_fetch_pc, i_riscv_bht_ex_valid, i_riscv_bht_ex_stall, i_riscv_bht_ex_pc,
           i_riscv_bht_ex_taken, i_riscv_bht_ex_target, i_riscv_bht_ex_pred_taken,
           i_riscv_bht_ex_pred_target,
    input  o_riscv_bht_pred_taken, o_riscv_bht_pred_target, o_riscv_bht_mispredict,
           o_riscv_bht_redirect_pc
  );
  modport slave (
    input  i_riscv_bht_fetch_pc, i_riscv_bht_ex_valid, i_riscv_bht_ex_stall, i_riscv_bht_ex_pc,
           i_riscv_bht_ex_taken, i_riscv_bht_ex_target, i_riscv_bht_ex_pred_taken,
           i_riscv_bht_ex_pred_target,
    output o_riscv_bht_pred_taken, o_riscv_bht_pred_target, o_riscv_bht_mispredict,
           o_riscv_bht_redirect_pc
  );
endinterface

// File: rtl/riscv_bht.sv
// riscv_bht: 2-bit counter branch history table with tagged targets; RISCV_BHT_GSHARE_EN adds gshare counter indexing
module riscv_bht #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 8
) (
  input logic        i_riscv_bht_clk,
  input logic        i_riscv_bht_rstn,
  riscv_bht_if.slave bus
);
  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [63:0]        target [ENTRIES];
  logic [IDX_W-1:0]   ghr, f_idx, f_cidx, e_idx, e_cidx;
  logic [TAG_W-1:0]   f_tag, e_tag;
  logic               f_hit, e_hit, upd, taken, wrong;
  logic [1:0]         e_ctr;
  logic               unused_fetch_bits;

  assign f_idx  = bus.i_riscv_bht_fetch_pc[IDX_W+1:2];
  assign f_tag  = bus.i_riscv_bht_fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign e_idx  = bus.i_riscv_bht_ex_pc[IDX_W+1:2];
  assign e_tag  = bus.i_riscv_bht_ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_cidx = f_idx ^ ghr;
  assign e_cidx = e_idx ^ ghr;
  assign taken  = bus.i_riscv_bht_ex_taken;
  assign f_hit  = valid[f_idx] && tag[f_idx] == f_tag;
  assign e_hit  = valid[e_idx] && tag[e_idx] == e_tag;
  assign e_ctr  = ctr[e_cidx];
  assign upd    = bus.i_riscv_bht_ex_valid & ~bus.i_riscv_bht_ex_stall & i_riscv_bht_rstn;
  assign wrong  = (bus.i_riscv_bht_ex_pred_taken != taken) |
                  (taken & (bus.i_riscv_bht_ex_pred_target != bus.i_riscv_bht_ex_target));
  assign unused_fetch_bits = ^{bus.i_riscv_bht_fetch_pc[63:IDX_W+TAG_W+2], bus.i_riscv_bht_fetch_pc[1:0]};

`ifdef RISCV_BHT_GSHARE_EN
  // non-speculative global history, shifted once per resolved branch
  always_ff @(posedge i_riscv_bht_clk)
    if (!i_riscv_bht_rstn) ghr <= '0;
    else if (upd) ghr <= {ghr[IDX_W-2:0], taken};
`else
  assign ghr = '0;
`endif

  // fetch prediction and execute redirect, all held at zero during reset
  always_comb begin
    bus.o_riscv_bht_pred_taken  = i_riscv_bht_rstn & f_hit & ctr[f_cidx][1];
    bus.o_riscv_bht_pred_target = (i_riscv_bht_rstn & f_hit) ? target[f_idx] : 64'd0;
    bus.o_riscv_bht_mispredict  = upd & wrong;
    bus.o_riscv_bht_redirect_pc = !(upd & wrong) ? 64'd0 :
                                  taken ? bus.i_riscv_bht_ex_target : bus.i_riscv_bht_ex_pc + 64'd4;
  end

  // valid bits and saturating counters: train on hit, allocate weakly-taken on taken miss
  always_ff @(posedge i_riscv_bht_clk)
    if (!i_riscv_bht_rstn) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd) begin
      if (e_hit) ctr[e_cidx] <= taken ? (e_ctr == 2'b11 ? 2'b11 : e_ctr + 2'd1)
                                      : (e_ctr == 2'b00 ? 2'b00 : e_ctr - 2'd1);
      else if (taken) begin
        valid[e_idx] <= 1'b1;
        ctr[e_cidx]  <= 2'b10;
      end
    end

  // tag and target storage is not reset; written only by taken resolutions
  always_ff @(posedge i_riscv_bht_clk)
    if (upd && taken) begin
      if (!e_hit) tag[e_idx] <= e_tag;
      target[e_idx] <= bus.i_riscv_bht_ex_target;
    end
endmodule
